// File: rtl/microcode_seq_if.sv
// Sequencer port bundle: fetch/bus handshake, CPU flags, control-word fields and
// sequencer outputs. The sequencer takes the slave side.
interface microcode_seq_if;
  logic [7:0] instr_byte;
  logic       instr_valid;
  logic       mem_ready;
  logic       flag_z;
  logic       flag_c;
  logic       ime;
  logic       irq_pending;
  logic       ctl_end;
  logic [9:0] ctl_next;
  logic       ctl_cond_en;
  logic [1:0] ctl_cond_sel;
  logic       ctl_cb_prefix;
  logic       ctl_halt;
  logic [9:0] uaddr;
  logic       instr_start;
  logic       irq_ack;
  logic       halted;
  logic       seq_err;

  modport master (
    output instr_byte, instr_valid, mem_ready, flag_z, flag_c, ime, irq_pending,
           ctl_end, ctl_next, ctl_cond_en, ctl_cond_sel, ctl_cb_prefix, ctl_halt,
    input  uaddr, instr_start, irq_ack, halted, seq_err
  );

  modport slave (
    input  instr_byte, instr_valid, mem_ready, flag_z, flag_c, ime, irq_pending,
           ctl_end, ctl_next, ctl_cond_en, ctl_cond_sel, ctl_cb_prefix, ctl_halt,
    output uaddr, instr_start, irq_ack, halted, seq_err
  );
endinterface

// File: rtl/microcode_seq.sv
// Microcode sequencer: drives the control-ROM address and walks each instruction's
// microwords, with CB chaining, conditional early exit, HALT, IRQ dispatch, watchdog.
module microcode_seq #(
  parameter logic [9:0] FETCH_ADDR = 10'd512,
  parameter logic [9:0] IRQ_ADDR   = 10'd520,
  parameter int         MAX_STEPS  = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  microcode_seq_if.slave   bus
);
  localparam int SW = $clog2(MAX_STEPS + 1);

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT} state_t;

  state_t        state_q, state_d;
  logic [9:0]    uaddr_q, uaddr_d;
  logic          cb_q, cb_d;
  logic [SW-1:0] step_q, step_d;
  logic          start_q, start_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic          halted;
  logic          cond_true;
  logic          boundary;
  logic          irq_take;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      uaddr_q <= FETCH_ADDR;
      cb_q    <= 1'b0;
      step_q  <= '0;
      start_q <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      uaddr_q <= uaddr_d;
      cb_q    <= cb_d;
      step_q  <= step_d;
      start_q <= start_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    case (bus.ctl_cond_sel)
      2'd0:    cond_true = !bus.flag_z;
      2'd1:    cond_true =  bus.flag_z;
      2'd2:    cond_true = !bus.flag_c;
      default: cond_true =  bus.flag_c;
    endcase
  end

  assign boundary = bus.ctl_end || (bus.ctl_cond_en && !cond_true);
  assign irq_take = bus.irq_pending && bus.ime;

  always_comb begin
    state_d = state_q;
    uaddr_d = uaddr_q;
    cb_d    = cb_q;
    step_d  = step_q;
    start_d = 1'b0;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (bus.mem_ready && bus.instr_valid) begin
          uaddr_d = {1'b0, cb_q, bus.instr_byte};
          cb_d    = 1'b0;
          step_d  = '0;
          start_d = 1'b1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (bus.mem_ready) begin
          // CB prefix re-enters FETCH directly, so no IRQ window opens mid-instruction
          if (bus.ctl_cb_prefix) begin
            cb_d    = 1'b1;
            uaddr_d = FETCH_ADDR;
            state_d = S_FETCH;
          end else if (bus.ctl_halt) begin
            uaddr_d = FETCH_ADDR;
            state_d = S_HALT;
          end else if (boundary) begin
            if (irq_take) begin
              uaddr_d = IRQ_ADDR;
              ack_d   = 1'b1;
              step_d  = '0;
            end else begin
              uaddr_d = FETCH_ADDR;
              state_d = S_FETCH;
            end
          end else if (step_q == SW'(MAX_STEPS)) begin
            err_d   = 1'b1;
            uaddr_d = FETCH_ADDR;
            state_d = S_FETCH;
          end else begin
            uaddr_d = bus.ctl_next;
            step_d  = step_q + 1'b1;
          end
        end
      end
      S_HALT: begin
        // Wake on any pending interrupt; dispatch it only if enabled
        if (bus.irq_pending) begin
          if (bus.ime) begin
            uaddr_d = IRQ_ADDR;
            ack_d   = 1'b1;
            step_d  = '0;
            state_d = S_EXEC;
          end else begin
            uaddr_d = FETCH_ADDR;
            state_d = S_FETCH;
          end
        end
      end
      default: begin
        uaddr_d = FETCH_ADDR;
        state_d = S_FETCH;
      end
    endcase
  end

  always_comb begin
    halted = (state_q == S_HALT);
  end

  assign bus.uaddr       = uaddr_q;
  assign bus.instr_start = start_q;
  assign bus.irq_ack     = ack_q;
  assign bus.seq_err     = err_q;
  assign bus.halted      = halted;
endmodule

// File: doc/microcode_seq.md
# microcode_seq

Microcode sequencer for the CPU core. Generates the 10-bit microcode address that indexes the opcode/subop control ROM, and consumes the sequencing fields of the returned control word to step through each instruction. It also handles CB-prefix chaining, conditional early termination, HALT, and interrupt dispatch at instruction boundaries. It sits between the fetch/bus unit and the control ROM; its `uaddr` output drives the ROM's opcode input directly.

## Interface
- `FETCH_ADDR`, default 10'd512: microcode address of the opcode-fetch routine.
- `IRQ_ADDR`, default 10'd520: microcode address of the interrupt-dispatch routine.
- `MAX_STEPS`, default 15: step-count limit for the watchdog.
- `clk` in 1: single system clock; all state changes on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `instr_byte` in 8: opcode byte returned by fetch.
- `instr_valid` in 1: `instr_byte` is valid this cycle.
- `mem_ready` in 1: bus ready. When 0, the sequencer stalls.
- `flag_z`, `flag_c` in 1 each: CPU flags used for condition evaluation.
- `ime` in 1: interrupt master enable.
- `irq_pending` in 1: at least one enabled interrupt is requested.
- `ctl_end` in 1: control-word field; the current microinstruction is the last one.
- `ctl_next` in 10: control-word field; next microcode address.
- `ctl_cond_en` in 1: control-word field; evaluate the condition.
- `ctl_cond_sel` in 2: condition select. 0 = NZ, 1 = Z, 2 = NC, 3 = C.
- `ctl_cb_prefix` in 1: control-word field; the instruction was 0xCB.
- `ctl_halt` in 1: control-word field; enter HALT.
- `uaddr` out 10: registered microcode address.
- `instr_start` out 1: one-cycle pulse when a new opcode is dispatched.
- `irq_ack` out 1: one-cycle pulse when interrupt dispatch begins.
- `halted` out 1: high while in the HALT state.
- `seq_err` out 1: one-cycle pulse on a watchdog abort.

## Operation
- States: FETCH, EXEC, HALT.
- Reset (`rst_n` = 0 at an edge) sets state FETCH, `uaddr` = FETCH_ADDR, `cb_mode` = 0, `step` = 0, and drives all pulse outputs and `halted` to 0. Reset overrides every other input in any state.
- **FETCH**
  - `uaddr` is held at FETCH_ADDR.
  - On `instr_valid` && `mem_ready`: `uaddr` <= `{1'b0, cb_mode, instr_byte}`, giving 0–255 for plain opcodes and 256–511 for CB opcodes.
  - In the same update: `cb_mode` <= 0, `step` <= 0, `instr_start` pulses, and state goes to EXEC.
- **EXEC**, on each cycle with `mem_ready` = 1, using the control word for the current `uaddr`. Priority is highest first:
  1. `ctl_cb_prefix`: `cb_mode` <= 1, go to FETCH. No interrupt check.
  2. `ctl_halt`: go to HALT.
  3. `ctl_end`, or `ctl_cond_en` with the selected condition false, is an instruction boundary.
  4. `step` == MAX_STEPS: `seq_err` pulses, `uaddr` <= FETCH_ADDR, go to FETCH.
  5. Otherwise `uaddr` <= `ctl_next`, `step` <= `step` + 1.
- **Boundary**
  - If `irq_pending` && `ime`: `uaddr` <= IRQ_ADDR, `irq_ack` pulses, stay in EXEC, `step` <= 0.
  - Otherwise `uaddr` <= FETCH_ADDR and go to FETCH.
  - The IRQ routine ends with `ctl_end` like any other instruction.
- **HALT**
  - `halted` = 1 and `uaddr` = FETCH_ADDR.
  - On `irq_pending`: if `ime`, take the IRQ path (`irq_ack`, EXEC, IRQ_ADDR); if not `ime`, go to FETCH. `halted` drops in the same update.
  - `mem_ready` is ignored in HALT.
- **Condition true** with `ctl_cond_en` and no `ctl_end`: advance to `ctl_next` as normal.
- **Stall**: `mem_ready` = 0 in FETCH or EXEC holds all state, `uaddr`, and `step`. No pulses fire.

## Timing
- `uaddr` is registered. The control ROM is combinational, so the control word for `uaddr` is valid in the same cycle and is sampled at the next edge.
- Opcode dispatch: `instr_valid` at edge N gives the opcode `uaddr` after edge N. The first microstep executes in cycle N+1.
- Each microstep takes 1 cycle plus any `mem_ready` stall cycles.
- A CB instruction takes a FETCH pass, then a second FETCH pass, with no cycle gap and no IRQ window in between.
- `instr_start`, `irq_ack`, and `seq_err` are high for exactly one cycle and never high together.
- Interrupts are sampled only at boundaries and at HALT exit. An interrupt that arrives mid-instruction waits for the next boundary.

## Test plan
- **Reset:** hold `rst_n` = 0 for 2 cycles with `instr_valid` = 1 and `instr_byte` = 0x3E → `uaddr` = 512, all outputs 0. After release, the next edge gives `uaddr` = 0x03E and an `instr_start` pulse.
- **CB chain:** fetch 0xCB; control word 0x0CB has `ctl_cb_prefix` = 1; `irq_pending` = `ime` = 1 → `uaddr` goes 0x0CB, 512, then fetching 0x37 gives 0x137 (311). No `irq_ack` is issued until 311's `ctl_end`.
- **Conditional:** `uaddr` 0x020 has `ctl_cond_en` = 1, `ctl_cond_sel` = 0 (NZ), `flag_z` = 1 → next `uaddr` = 512. With `flag_z` = 0 and `ctl_next` = 530 → next `uaddr` = 530 and `step` = 1.
- **Stall:** `mem_ready` = 0 for 3 cycles mid-instruction at `uaddr` = 530 → `uaddr` stays 530 with no pulses. It advances on the first cycle with `mem_ready` = 1.
- **HALT:** `ctl_halt` = 1 → `halted` = 1. Raise `irq_pending` with `ime` = 0 → `uaddr` = 512 and `halted` = 0. Repeat with `ime` = 1 → `uaddr` = 520, `irq_ack` pulses once.
- **Watchdog:** the control ROM chains 16 microwords with `ctl_end` = 0 → after 15 advances, `seq_err` pulses and `uaddr` = 512.
